// File: rtl/tetron_rotation_ctrl.sv
// Rotation sequencer for the active tetromino: drives the shaper with a
// candidate rotation, waits for its offsets to settle, then walks the
// wall-kick shifts through the collision checker and commits or reverts.
module tetron_rotation_ctrl #(
  parameter int SHAPER_LATENCY = 1,
  parameter bit KICK_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       piece_spawn,
  input  logic       piece_lock,
  input  logic       rot_cw,
  input  logic       rot_ccw,
  input  logic       chk_ack,
  input  logic       chk_collide,
  output logic       shaper_active,
  output logic [2:0] shaper_rotation,
  output logic       chk_req,
  output logic [4:0] chk_hshift,
  output logic [2:0] rotation,
  output logic       busy,
  output logic       done,
  output logic       accepted,
  output logic [4:0] kick_delta
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, NEXT} state_t;

  localparam logic [2:0] LAT = 3'(SHAPER_LATENCY);

  state_t     state;
  logic [1:0] kidx;
  logic [2:0] cnt;
  logic [1:0] next_rot;
  logic       req_ok;
  logic       last_kick;

  // Kick order: centre, one column left, one column right.
  function automatic logic [4:0] kick_shift(input logic [1:0] k);
    case (k)
      2'd1:    return 5'h1F;
      2'd2:    return 5'h01;
      default: return 5'h00;
    endcase
  endfunction

  // Candidate rotation wraps in two bits; ccw is +3 mod 4.
  assign next_rot  = rot_cw ? (rotation[1:0] + 2'd1) : (rotation[1:0] + 2'd3);
  assign req_ok    = shaper_active & (rot_cw ^ rot_ccw);
  assign last_kick = KICK_EN ? (kidx == 2'd2) : 1'b1;

  // Sequencer FSM; while busy, shaper_rotation holds the candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      kidx            <= 2'd0;
      cnt             <= 3'd0;
      shaper_active   <= 1'b0;
      shaper_rotation <= 3'd0;
      chk_req         <= 1'b0;
      chk_hshift      <= 5'd0;
      rotation        <= 3'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      accepted        <= 1'b0;
      kick_delta      <= 5'd0;
    end else begin
      done       <= 1'b0;
      accepted   <= 1'b0;
      kick_delta <= 5'd0;
      if (piece_spawn || piece_lock) begin
        // Abort whatever is in flight; spawn wins over lock.
        state           <= IDLE;
        kidx            <= 2'd0;
        cnt             <= 3'd0;
        shaper_active   <= piece_spawn;
        shaper_rotation <= 3'd0;
        chk_req         <= 1'b0;
        chk_hshift      <= 5'd0;
        rotation        <= 3'd0;
        busy            <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_ok) begin
              shaper_rotation <= {1'b0, next_rot};
              busy            <= 1'b1;
              kidx            <= 2'd0;
              chk_hshift      <= 5'd0;
              cnt             <= 3'd0;
              state           <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt == LAT) begin
              chk_req <= 1'b1;
              state   <= CHECK;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          CHECK: begin
            if (chk_ack) begin
              chk_req <= 1'b0;
              if (!chk_collide) begin
                rotation   <= shaper_rotation;
                done       <= 1'b1;
                accepted   <= 1'b1;
                kick_delta <= chk_hshift;
                chk_hshift <= 5'd0;
                busy       <= 1'b0;
                state      <= IDLE;
              end else if (!last_kick) begin
                // Shift only moves the column, so no re-settle needed.
                kidx       <= kidx + 2'd1;
                chk_hshift <= kick_shift(kidx + 2'd1);
                state      <= NEXT;
              end else begin
                done            <= 1'b1;
                shaper_rotation <= rotation;
                chk_hshift      <= 5'd0;
                busy            <= 1'b0;
                state           <= IDLE;
              end
            end
          end
          NEXT: begin
            chk_req <= 1'b1;
            state   <= CHECK;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
